// File: rtl/parity_rx_pkg.sv
// Shared types and helpers for the parity frame receiver.
// Holds the FSM state enum, default widths and a saturating increment.
package parity_rx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PAR
    } rx_state_e;

    localparam int DEF_DATA_W = 16;
    localparam int DEF_CNT_W  = 8;

    // Saturating increment of a w-bit value carried in 32 bits (w <= 32).
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] mx;
        mx = 32'hFFFF_FFFF >> (32 - w);
        return (v >= mx) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// XOR-reduction of a W-bit word; shared with the transmit-side generator.
// Ports: d (word in), p (XOR of all bits of d).
module parity_xor_tree #(
    parameter int W = 16
) (
    input  logic [W-1:0] d,
    output logic         p
);

    assign p = ^d;

endmodule

// File: rtl/parity_frame_rx.sv
// Bit-serial parity frame receiver with a one-entry valid/ready buffer.
// Ports: clk/rst_n, serial in (sin_*), buffered out (out_*), stats (clr/cnt/sticky).
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit PARITY_ODD = 1'b0,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sin_valid,
    input  logic              sin_bit,
    input  logic              sin_start,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_perr,
    input  logic              clr_stats,
    output logic [CNT_W-1:0]  perr_cnt,
    output logic [CNT_W-1:0]  frame_err_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic              ovf_sticky
);

    localparam int CW = $clog2(DATA_W) + 1;

    rx_state_e         r_state;
    rx_state_e         w_state_nxt;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic              w_start;
    logic              w_data_bit;
    logic              w_par_bit;
    logic              w_abort;
    logic              w_xor;
    logic              w_perr;
    logic              w_hs;
    logic              w_load;
    logic              w_drop;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_perr;
    logic [CNT_W-1:0]  r_perr_cnt;
    logic [CNT_W-1:0]  r_fe_cnt;
    logic [CNT_W-1:0]  r_drop_cnt;
    logic              r_ovf;

    assign w_start = sin_valid & sin_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (w_start) w_state_nxt = DATA;
            DATA: begin
                if (w_start)
                    w_state_nxt = DATA;
                else if (sin_valid && r_cnt == CW'(DATA_W - 1))
                    w_state_nxt = PAR;
            end
            PAR: begin
                if (w_start)       w_state_nxt = DATA;
                else if (sin_valid) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // A start strobe outside IDLE aborts the partial frame.
    always_comb begin
        w_data_bit = 1'b0;
        w_par_bit  = 1'b0;
        w_abort    = 1'b0;
        unique case (r_state)
            IDLE: ;
            DATA: begin
                w_abort    = w_start;
                w_data_bit = sin_valid & ~sin_start;
            end
            PAR: begin
                w_abort   = w_start;
                w_par_bit = sin_valid & ~sin_start;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        if (w_start) begin
            w_shift_nxt = {{(DATA_W-1){1'b0}}, sin_bit};
        end else if (w_data_bit) begin
            for (int i = 0; i < DATA_W; i++)
                if (r_cnt == CW'(i)) w_shift_nxt[i] = sin_bit;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else begin
            r_shift <= w_shift_nxt;
            if (w_start)         r_cnt <= CW'(1);
            else if (w_data_bit) r_cnt <= r_cnt + CW'(1);
            else if (w_par_bit)  r_cnt <= '0;
        end
    end

    parity_xor_tree #(.W(DATA_W)) u_xor (
        .d (r_shift),
        .p (w_xor)
    );

    assign w_perr = sin_bit ^ w_xor ^ PARITY_ODD;
    assign w_hs   = r_out_valid & out_ready;
    // A full buffer can still take the frame if it drains this cycle.
    assign w_load = w_par_bit & (~r_out_valid | out_ready);
    assign w_drop = w_par_bit & r_out_valid & ~out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_perr  <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_shift;
            r_out_perr  <= w_perr;
        end else if (w_hs) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perr_cnt <= '0;
            r_fe_cnt   <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else if (clr_stats) begin
            r_perr_cnt <= '0;
            r_fe_cnt   <= '0;
            r_drop_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_abort)
                r_fe_cnt <= CNT_W'(sat_inc(32'(r_fe_cnt), CNT_W));
            if (w_load & w_perr)
                r_perr_cnt <= CNT_W'(sat_inc(32'(r_perr_cnt), CNT_W));
            if (w_drop) begin
                r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), CNT_W));
                r_ovf      <= 1'b1;
            end
        end
    end

    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign out_perr      = r_out_perr;
    assign perr_cnt      = r_perr_cnt;
    assign frame_err_cnt = r_fe_cnt;
    assign drop_cnt      = r_drop_cnt;
    assign ovf_sticky    = r_ovf;

endmodule

// File: tb/tb_parity_frame_rx.sv
// Randomized scoreboard bench for parity_frame_rx.
// Frame-level queue model predicts words, buffer occupancy and statistics.
module tb_parity_frame_rx;

    localparam int DW   = 16;
    localparam int CNTW = 2;
    localparam int SATV = (1 << CNTW) - 1;

    typedef struct {
        logic [DW-1:0] d;
        bit            p;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sin_valid = 1'b0;
    logic            sin_bit = 1'b0;
    logic            sin_start = 1'b0;
    logic            out_ready = 1'b0;
    logic            clr_stats = 1'b0;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_perr;
    logic [CNTW-1:0] perr_cnt;
    logic [CNTW-1:0] frame_err_cnt;
    logic [CNTW-1:0] drop_cnt;
    logic            ovf_sticky;

    logic            o_valid_odd;
    logic [DW-1:0]   o_data_odd;
    logic            o_perr_odd;
    logic [CNTW-1:0] o_pc_odd;
    logic [CNTW-1:0] o_fe_odd;
    logic [CNTW-1:0] o_dc_odd;
    logic            o_ovf_odd;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rand_mode = 1'b0;

    exp_t q_exp[$];
    exp_t q_odd[$];
    bit   q_bits[$];
    bit   m_full;
    int   m_perr, m_fe, m_drop;
    bit   m_ovf;

    always #5 clk = ~clk;

    parity_frame_rx #(
        .DATA_W(DW), .PARITY_ODD(1'b0), .CNT_W(CNTW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_start(sin_start),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_perr(out_perr),
        .clr_stats(clr_stats), .perr_cnt(perr_cnt),
        .frame_err_cnt(frame_err_cnt), .drop_cnt(drop_cnt),
        .ovf_sticky(ovf_sticky)
    );

    parity_frame_rx #(
        .DATA_W(DW), .PARITY_ODD(1'b1), .CNT_W(CNTW)
    ) u_odd (
        .clk(clk), .rst_n(rst_n),
        .sin_valid(sin_valid), .sin_bit(sin_bit), .sin_start(sin_start),
        .out_valid(o_valid_odd), .out_ready(1'b1),
        .out_data(o_data_odd), .out_perr(o_perr_odd),
        .clr_stats(clr_stats), .perr_cnt(o_pc_odd),
        .frame_err_cnt(o_fe_odd), .drop_cnt(o_dc_odd),
        .ovf_sticky(o_ovf_odd)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat(input int c);
        return (c < SATV) ? c + 1 : c;
    endfunction

    // Frame-level reference: bits collected in a queue, buffer as a flag.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_bits.delete();
            q_exp.delete();
            q_odd.delete();
            m_full = 0;
            m_perr = 0;
            m_fe   = 0;
            m_drop = 0;
            m_ovf  = 0;
        end else begin
            bit hs, ld, dr, fe, pe;
            logic [DW-1:0] w;
            hs = m_full && out_ready;
            ld = 0; dr = 0; fe = 0; pe = 0;
            if (sin_valid) begin
                if (sin_start) begin
                    if (q_bits.size() > 0) fe = 1;
                    q_bits.delete();
                    q_bits.push_back(sin_bit);
                end else if (q_bits.size() == DW) begin
                    for (int i = 0; i < DW; i++) w[i] = q_bits[i];
                    pe = (sin_bit != (^w));
                    q_odd.push_back('{d: w, p: (sin_bit != !(^w))});
                    if (!m_full || out_ready) begin
                        ld = 1;
                        q_exp.push_back('{d: w, p: pe});
                    end else begin
                        dr = 1;
                    end
                    q_bits.delete();
                end else if (q_bits.size() > 0) begin
                    q_bits.push_back(sin_bit);
                end
            end
            if (ld)      m_full = 1;
            else if (hs) m_full = 0;
            if (clr_stats) begin
                m_perr = 0; m_fe = 0; m_drop = 0; m_ovf = 0;
            end else begin
                if (fe)       m_fe = sat(m_fe);
                if (ld && pe) m_perr = sat(m_perr);
                if (dr) begin
                    m_drop = sat(m_drop);
                    m_ovf  = 1;
                end
            end
        end
    end

    // Monitor: pops on each handshake, tracks occupancy and statistics.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(out_valid), int'(m_full));
            chk("perr_cnt", int'(perr_cnt), m_perr);
            chk("frame_err_cnt", int'(frame_err_cnt), m_fe);
            chk("drop_cnt", int'(drop_cnt), m_drop);
            chk("ovf_sticky", int'(ovf_sticky), int'(m_ovf));
            if (out_valid && out_ready) begin
                if (q_exp.size() == 0) begin
                    chk("unexpected_word", 1, 0);
                end else begin
                    exp_t e;
                    e = q_exp.pop_front();
                    chk("out_data", int'(out_data), int'(e.d));
                    chk("out_perr", int'(out_perr), int'(e.p));
                end
            end
            if (o_valid_odd) begin
                if (q_odd.size() == 0) begin
                    chk("odd_unexpected", 1, 0);
                end else begin
                    exp_t e;
                    e = q_odd.pop_front();
                    chk("odd_data", int'(o_data_odd), int'(e.d));
                    chk("odd_perr", int'(o_perr_odd), int'(e.p));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        if (rand_mode) begin
            out_ready = 1'($urandom_range(0, 1));
            clr_stats = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic idle(input int n);
        sin_valid = 1'b0;
        sin_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input bit b, input bit s);
        sin_valid = 1'b1;
        sin_bit   = b;
        sin_start = s;
        tick();
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    task automatic send_frame(
        input logic [DW-1:0] d,
        input bit            bad,
        input int            gap_at,
        input bit            rdy_par,
        input bit            clr_par
    );
        for (int i = 0; i < DW; i++) begin
            if (i == gap_at) idle(5);
            send_bit(d[i], i == 0);
        end
        if (rdy_par) out_ready = 1'b1;
        if (clr_par) clr_stats = 1'b1;
        send_bit((^d) ^ bad, 1'b0);
        if (clr_par) clr_stats = 1'b0;
    endtask

    task automatic clear();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_perr", int'(out_perr), 0);
        chk("rst_perr_cnt", int'(perr_cnt), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        chk("rst_ovf", int'(ovf_sticky), 0);
        rst_n = 1'b1;
        tick();

        out_ready = 1'b1;
        send_frame(16'hA5A5, 0, 99, 0, 0);
        chk("a5a5_valid", int'(out_valid), 1);
        chk("a5a5_data", int'(out_data), 'hA5A5);
        chk("a5a5_perr", int'(out_perr), 0);
        idle(2);

        send_frame(16'h0001, 1, 99, 0, 0);
        chk("bad_perr", int'(out_perr), 1);
        chk("bad_odd_perr", int'(o_perr_odd), 0);
        idle(1);
        chk("bad_perr_cnt", int'(perr_cnt), 1);

        out_ready = 1'b0;
        send_frame(16'h1234, 0, 99, 0, 0);
        send_frame(16'h5678, 0, 99, 0, 0);
        idle(1);
        chk("bp_hold_data", int'(out_data), 'h1234);
        chk("bp_drop_cnt", int'(drop_cnt), 1);
        chk("bp_ovf", int'(ovf_sticky), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_drained", int'(out_valid), 0);

        clear();
        send_frame(16'h1111, 0, 99, 0, 0);
        send_frame(16'hBEEF, 0, 99, 1, 0);
        chk("sim_valid", int'(out_valid), 1);
        chk("sim_data", int'(out_data), 'hBEEF);
        chk("sim_drop", int'(drop_cnt), 0);
        idle(2);

        clear();
        send_bit(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
        send_frame(16'h00FF, 0, 8, 0, 0);
        chk("es_data", int'(out_data), 'h00FF);
        chk("es_perr", int'(out_perr), 0);
        chk("es_fe_cnt", int'(frame_err_cnt), 1);
        idle(2);

        clear();
        for (int k = 0; k < 5; k++) send_frame(DW'($urandom), 1, 99, 0, 0);
        idle(1);
        chk("sat_perr_cnt", int'(perr_cnt), 3);
        send_frame(DW'($urandom), 1, 99, 0, 1);
        chk("clr_perr_cnt", int'(perr_cnt), 0);
        idle(2);

        rand_mode = 1'b1;
        for (int k = 0; k < 250; k++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0) begin
                int n;
                n = $urandom_range(1, DW);
                send_bit(1'($urandom_range(0, 1)), 1'b1);
                for (int i = 1; i < n; i++)
                    send_bit(1'($urandom_range(0, 1)), 1'b0);
            end else if (r == 1) begin
                send_bit(1'($urandom_range(0, 1)), 1'b0);
            end else begin
                send_frame(DW'($urandom), ($urandom_range(0, 3) == 0),
                           $urandom_range(0, 60), 0, 0);
            end
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        rand_mode = 1'b0;
        clr_stats = 1'b0;
        out_ready = 1'b1;
        idle(4);

        out_ready = 1'b0;
        send_frame(16'h4242, 0, 99, 0, 0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, i == 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data", int'(out_data), 0);
        chk("arst_perr_cnt", int'(perr_cnt), 0);
        chk("arst_fe_cnt", int'(frame_err_cnt), 0);
        chk("arst_ovf", int'(ovf_sticky), 0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        send_frame(16'hC3C3, 0, 99, 0, 0);
        chk("post_rst_data", int'(out_data), 'hC3C3);
        idle(10);

        chk("sb_empty", q_exp.size(), 0);
        chk("sb_odd_empty", q_odd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
Name: parity_frame_rx

Overview:
Bit-serial receiver for parity-protected frames; it is the receive end of the 16-bit parity generator path. It assembles DATA_W data bits (LSB first), then one parity bit, and checks the frame against the XOR-reduction of the data. It delivers the word through a one-entry valid/ready output buffer and keeps error and drop statistics for the status block.

Parameters:
DATA_W, 16, data bits per frame (2..32)
PARITY_ODD, 0, 0: transmitted parity bit = XOR of data (even overall); 1: inverted XOR (odd overall)
CNT_W, 8, width of saturating statistics counters

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
sin_valid  in  1  serial bit strobe; one bit per cycle when high
sin_bit  in  1  serial data/parity bit
sin_start  in  1  qualifies the current bit as data bit 0 of a new frame; ignored unless sin_valid
out_valid  out  1  output buffer holds a frame
out_ready  in  1  consumer accepts the frame when out_valid & out_ready
out_data  out  DATA_W  received data word
out_perr  out  1  parity mismatch for out_data
clr_stats  in  1  synchronous clear of all counters and sticky flags
perr_cnt  out  CNT_W  frames delivered with parity error, saturating
frame_err_cnt  out  CNT_W  frames aborted by an early sin_start, saturating
drop_cnt  out  CNT_W  completed frames dropped because the buffer was full, saturating
ovf_sticky  out  1  set on any drop; cleared by clr_stats or reset

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, bit counter=0, shift register=0. out_valid=0, out_data=0, out_perr=0, all counters=0, ovf_sticky=0.
- FSM states: IDLE, DATA, PAR.
  - IDLE: sin_valid & sin_start -> store bit 0, cnt=1, go to DATA. sin_valid without sin_start is ignored (no count).
  - DATA: each sin_valid stores sin_bit at position cnt, then cnt++. When bit DATA_W-1 is stored -> PAR.
  - PAR: the next sin_valid is the parity bit. Compute exp = XOR(data) ^ PARITY_ODD and perr = sin_bit ^ exp. Then attempt a buffer load and go to IDLE.
- Early start: sin_valid & sin_start while in DATA or PAR aborts the partial frame and increments frame_err_cnt. The current bit becomes data bit 0 of the new frame (cnt=1, state DATA). An abort in PAR does not load the buffer.
- sin_valid low: state and counter hold; gaps between bits are unlimited.
- Buffer load, in the cycle the parity bit is accepted:
  - If the buffer is empty, or out_valid & out_ready in the same cycle, load it. Next cycle: out_valid=1, out_data=word, out_perr=perr. If perr, increment perr_cnt.
  - Otherwise drop the frame, increment drop_cnt, set ovf_sticky. Existing buffer contents are untouched.
- Latency: out_valid rises on the cycle after the parity bit is accepted.
- out_data and out_perr hold stable while out_valid & ~out_ready. A handshake with no simultaneous load clears out_valid next cycle; out_data retains its value.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_stats has priority over an increment in the same cycle: the result is 0. It does not affect the FSM or the buffer.
- A perr increment and a drop never happen in the same cycle (they are mutually exclusive by construction).
- A reset mid-frame discards the partial frame and any buffered frame.

Decomposition:
- Package parity_rx_pkg holds:
  - state enum rx_state_e {IDLE, DATA, PAR};
  - default DATA_W/CNT_W localparams;
  - a function for saturating increment.
- Sub-module parity_xor_tree: combinational, parameter W, input [W-1:0] d, output p = ^d. It is instantiated on the assembled shift register, and the transmitter's generator reuses it.

Test Plan:
- Even parity: send start + data 16'hA5A5 LSB first, then parity 0, out_ready=1 -> out_valid one cycle after the parity bit, out_data=16'hA5A5, out_perr=0, perr_cnt=0.
- Bad parity: data 16'h0001, parity 0 -> out_perr=1, perr_cnt=1. Repeat with PARITY_ODD=1 and parity 0 -> out_perr=0.
- Backpressure/drop: out_ready=0, send frames 16'h1234 (good), then 16'h5678 -> out_data stays 16'h1234, drop_cnt=1, ovf_sticky=1. Then pulse out_ready -> out_valid=0 next cycle.
- Load with simultaneous handshake: buffer full, out_ready=1 in the same cycle as the parity bit of 16'hBEEF -> out_valid stays 1, out_data=16'hBEEF, drop_cnt=0.
- Early start: after 7 data bits, assert sin_start with a bit, then complete frame 16'h00FF with valid parity -> frame_err_cnt=1, out_data=16'h00FF, out_perr=0. A gap of 5 idle cycles mid-frame changes nothing.
- Saturation/clear: CNT_W=2, send 5 bad-parity frames -> perr_cnt=3. Assert clr_stats in the cycle of a 6th bad frame's load -> perr_cnt=0. Async rst_n low mid-frame -> all outputs 0 immediately.
